// File: rtl/prefetch_queue.sv
// Six-byte instruction prefetch queue with a single-request word bus.
// Fetches little-endian words at CS:IP and hands bytes to the decoder.
module prefetch_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    output logic [7:0]  q_byte,
    output logic [15:0] q_ip,
    output logic        q_valid,
    input  logic        q_rd,
    output logic [2:0]  q_count,
    output logic        req,
    input  logic        ack,
    output logic        rw,
    output logic [15:0] dtw,
    input  logic [15:0] dtr,
    output logic [19:0] adr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } state_t;

    state_t      r_state;
    logic [7:0]  r_mem [6];
    logic [2:0]  r_head;
    logic [2:0]  r_count;
    logic [15:0] r_cs;
    logic [15:0] r_fip;
    logic [15:0] r_qip;
    logic        r_req_q;
    logic [19:0] r_adr;

    logic [19:0] w_phys;
    logic        w_odd;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_n;
    logic [2:0]  w_inc;
    logic [2:0]  w_dec;
    logic [2:0]  w_tail;
    logic [2:0]  w_tail1;
    logic [2:0]  w_head1;

    function automatic logic [2:0] wrap6(input logic [3:0] s);
        logic [3:0] t;
        t = (s >= 4'd6) ? s - 4'd6 : s;
        return t[2:0];
    endfunction

    assign w_phys  = {r_cs, 4'h0} + {4'h0, r_fip};
    assign w_odd   = r_fip[0];
    assign w_pop   = q_rd && (r_count != 3'd0);
    assign w_push  = (r_state == FETCH) && ack && !flush;
    assign w_n     = w_odd ? 2'd1 : 2'd2;
    assign w_inc   = w_push ? {1'b0, w_n} : 3'd0;
    assign w_dec   = {2'b00, w_pop};
    assign w_tail  = wrap6({1'b0, r_head} + {1'b0, r_count});
    assign w_tail1 = wrap6({1'b0, r_head} + {1'b0, r_count} + 4'd1);
    assign w_head1 = wrap6({1'b0, r_head} + 4'd1);

    // Byte storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (w_odd) begin
                r_mem[w_tail]  <= dtr[15:8];
            end else begin
                r_mem[w_tail]  <= dtr[7:0];
                r_mem[w_tail1] <= dtr[15:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req_q <= 1'b0;
            r_adr   <= 20'h0;
            r_cs    <= 16'hFFFF;
            r_fip   <= 16'h0;
            r_qip   <= 16'h0;
            r_head  <= 3'd0;
            r_count <= 3'd0;
        end else if (flush) begin
            r_cs    <= new_cs;
            r_fip   <= new_ip;
            r_qip   <= new_ip;
            r_head  <= 3'd0;
            r_count <= 3'd0;
            // An ack arriving with flush closes the bus cycle; its data is dropped.
            unique case (r_state)
                IDLE: r_state <= IDLE;
                FETCH, DISCARD: begin
                    if (ack) begin
                        r_state <= IDLE;
                        r_req_q <= 1'b0;
                    end else begin
                        r_state <= DISCARD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end else begin
            if (w_pop) begin
                r_head <= w_head1;
                r_qip  <= r_qip + 16'd1;
            end
            r_count <= r_count + w_inc - w_dec;
            unique case (r_state)
                IDLE: begin
                    if (r_count <= 3'd4) begin
                        r_state <= FETCH;
                        r_req_q <= 1'b1;
                        r_adr   <= {w_phys[19:1], 1'b0};
                    end
                end
                FETCH: begin
                    if (ack) begin
                        r_state <= IDLE;
                        r_req_q <= 1'b0;
                        r_fip   <= r_fip + {14'd0, w_n};
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        r_state <= IDLE;
                        r_req_q <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req     = r_req_q & ~ack;
    assign adr     = r_adr;
    assign rw      = 1'b0;
    assign dtw     = 16'h0;
    assign q_byte  = r_mem[r_head];
    assign q_ip    = r_qip;
    assign q_valid = (r_count != 3'd0);
    assign q_count = r_count;

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: a bus model feeds words, a
// reference queue predicts decoder bytes, a monitor checks every pop.
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] new_cs = 16'h0;
    logic [15:0] new_ip = 16'h0;
    logic [7:0]  q_byte;
    logic [15:0] q_ip;
    logic        q_valid;
    logic        q_rd = 1'b0;
    logic [2:0]  q_count;
    logic        req;
    logic        ack = 1'b0;
    logic        rw;
    logic [15:0] dtw;
    logic [15:0] dtr = 16'h0;
    logic [19:0] adr;

    prefetch_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .new_cs(new_cs), .new_ip(new_ip),
        .q_byte(q_byte), .q_ip(q_ip), .q_valid(q_valid),
        .q_rd(q_rd), .q_count(q_count),
        .req(req), .ack(ack), .rw(rw), .dtw(dtw),
        .dtr(dtr), .adr(adr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] ip;
    } ent_t;

    int errors = 0;
    int checks = 0;

    ent_t        sb[$];
    ent_t        pop_log[$];
    logic [19:0] adr_log[$];
    logic [15:0] dq[$];

    logic [15:0] m_cs = 16'hFFFF;
    logic [15:0] m_fip = 16'h0;
    bit          outst = 0;
    bit          stale = 0;
    logic [19:0] out_adr = 20'h0;
    int          wait_cnt = 0;
    int          prev_sz = 0;
    int          cur_sz = 0;

    int          ack_dly = 0;
    int unsigned rd_pct = 0;
    int unsigned fl_pm = 0;
    bit          hold_ack = 0;
    bit          rd_on_ack = 0;
    bit          force_ack = 0;
    bit          rst_cmd = 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model();
        bit          real_ack;
        logic [19:0] p;
        if (rst) begin
            sb.delete();
            m_cs = 16'hFFFF;
            m_fip = 16'h0;
            outst = 0;
            stale = 0;
            return;
        end
        real_ack = ack && outst;
        if (!outst && req) begin
            outst = 1;
            out_adr = adr;
            wait_cnt = (ack_dly < 0) ? int'($urandom_range(3)) : ack_dly;
            chk("admit", {31'd0, prev_sz <= 4}, 32'd1);
        end
        if (real_ack) begin
            chk("adr_hold", adr, out_adr);
            adr_log.push_back(adr);
        end
        if (flush) begin
            sb.delete();
            m_cs = new_cs;
            m_fip = new_ip;
            stale = outst && !real_ack;
        end else if (real_ack) begin
            if (stale) begin
                stale = 0;
            end else begin
                p = {m_cs, 4'h0} + {4'h0, m_fip};
                chk("adr", adr, {p[19:1], 1'b0});
                if (m_fip[0]) begin
                    sb.push_back({dtr[15:8], m_fip});
                    m_fip = m_fip + 16'd1;
                end else begin
                    sb.push_back({dtr[7:0], m_fip});
                    sb.push_back({dtr[15:8], m_fip + 16'd1});
                    m_fip = m_fip + 16'd2;
                end
            end
        end
        if (real_ack) outst = 0;
    endtask

    task automatic step(input bit f = 1'b0,
                        input logic [15:0] cs = 16'h0,
                        input logic [15:0] ip = 16'h0);
        @(posedge clk);
        #1;
        rst = rst_cmd;
        prev_sz = cur_sz;
        cur_sz = sb.size();
        ack = 1'b0;
        if (force_ack) begin
            ack = 1'b1;
            dtr = 16'($urandom);
            force_ack = 0;
        end else if (outst && !hold_ack) begin
            if (wait_cnt == 0) begin
                ack = 1'b1;
                if (dq.size() != 0) dtr = dq.pop_front();
                else dtr = 16'($urandom);
            end else begin
                wait_cnt--;
            end
        end
        q_rd = rd_on_ack ? ack : ($urandom_range(99) < rd_pct);
        flush = f;
        new_cs = cs;
        new_ip = ip;
        if (!f && !ack && $urandom_range(999) < fl_pm) begin
            flush = 1'b1;
            new_cs = 16'($urandom);
            new_ip = 16'($urandom);
        end
        #6;
        model();
    endtask

    task automatic run_acks(input int n, input string nm);
        int k;
        k = 0;
        while (adr_log.size() < n && k < 200) begin
            step();
            k++;
        end
        chk(nm, adr_log.size(), n);
    endtask

    task automatic do_reset();
        rst_cmd = 1;
        step();
        step();
        chk("rst_adr", adr, 20'h0);
        chk("rst_req", req, 1'b0);
        chk("rst_cnt", q_count, 3'd0);
        chk("rst_valid", q_valid, 1'b0);
        chk("rst_qip", q_ip, 16'h0);
        chk("rw_dtw", {rw, dtw}, 17'h0);
        rst_cmd = 0;
        adr_log.delete();
        pop_log.delete();
        dq.delete();
        hold_ack = 0;
        rd_on_ack = 0;
        rd_pct = 0;
        fl_pm = 0;
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            chk("q_count", q_count, sb.size());
            chk("q_valid", q_valid, sb.size() != 0);
            if (q_rd && q_valid && sb.size() != 0) begin
                e = sb.pop_front();
                chk("q_byte", q_byte, e.b);
                chk("q_ip", q_ip, e.ip);
                pop_log.push_back({q_byte, q_ip});
            end
        end
    end

    initial begin
        int k;
        // reset release, first fetches and byte order
        do_reset();
        dq.push_back(16'h3412);
        dq.push_back(16'h7856);
        ack_dly = 1;
        step();
        run_acks(2, "boot_acks");
        chk("boot_adr0", adr_log[0], 20'hFFFF0);
        chk("boot_adr1", adr_log[1], 20'hFFFF2);
        rd_pct = 100;
        repeat (4) step();
        rd_pct = 0;
        chk("boot_pops", pop_log.size(), 4);
        chk("boot_b0", {pop_log[0].b, pop_log[0].ip}, 24'h12_0000);
        chk("boot_b1", {pop_log[1].b, pop_log[1].ip}, 24'h34_0001);
        chk("boot_b2", {pop_log[2].b, pop_log[2].ip}, 24'h56_0002);
        chk("boot_b3", {pop_log[3].b, pop_log[3].ip}, 24'h78_0003);

        // fill to six, admission threshold
        do_reset();
        ack_dly = 0;
        repeat (40) step();
        chk("full_cnt", q_count, 3'd6);
        chk("full_fetches", adr_log.size(), 3);
        chk("full_req", req, 1'b0);
        rd_pct = 100;
        step();
        rd_pct = 0;
        repeat (6) step();
        chk("five_fetches", adr_log.size(), 3);
        chk("five_req", req, 1'b0);
        rd_pct = 100;
        step();
        rd_pct = 0;
        repeat (6) step();
        chk("four_fetches", adr_log.size(), 4);
        chk("four_cnt", q_count, 3'd6);

        // odd fetch pointer after flush
        do_reset();
        dq.push_back(16'hAB5A);
        ack_dly = 1;
        step(1'b1, 16'h1000, 16'h0005);
        run_acks(2, "odd_acks");
        chk("odd_adr0", adr_log[0], 20'h10004);
        chk("odd_adr1", adr_log[1], 20'h10006);
        rd_pct = 100;
        step();
        rd_pct = 0;
        chk("odd_pop", {pop_log[0].b, pop_log[0].ip}, 24'hAB_0005);

        // flush while a request is outstanding
        do_reset();
        ack_dly = 3;
        step();
        k = 0;
        while (!outst && k < 20) begin
            step();
            k++;
        end
        chk("disc_req_seen", outst, 1'b1);
        step(1'b1, 16'h2000, 16'h0100);
        run_acks(1, "disc_ack");
        step();
        chk("disc_cnt", q_count, 3'd0);
        run_acks(2, "disc_acks");
        chk("disc_adr0", adr_log[0], 20'hFFFF0);
        chk("disc_adr1", adr_log[1], 20'h20100);

        // pop and push in the same cycle
        do_reset();
        ack_dly = 0;
        step(1'b1, 16'h0000, 16'h0001);
        run_acks(2, "rdack_pre");
        hold_ack = 1;
        repeat (4) step();
        chk("rdack_cnt3", q_count, 3'd3);
        rd_on_ack = 1;
        hold_ack = 0;
        run_acks(3, "rdack_ack");
        hold_ack = 1;
        rd_on_ack = 0;
        step();
        chk("rdack_cnt4", q_count, 3'd4);
        hold_ack = 0;

        // 64K wrap of the fetch pointer
        do_reset();
        ack_dly = 0;
        step(1'b1, 16'hF000, 16'hFFFE);
        run_acks(2, "wrap_acks");
        chk("wrap_adr0", adr_log[0], 20'hFFFFE);
        chk("wrap_adr1", adr_log[1], 20'hF0000);

        // reset in the middle of a bus cycle, then a late ack
        do_reset();
        ack_dly = 5;
        step();
        k = 0;
        while (!outst && k < 20) begin
            step();
            k++;
        end
        rst_cmd = 1;
        step();
        step();
        rst_cmd = 0;
        adr_log.delete();
        force_ack = 1;
        step();
        step();
        chk("late_cnt", q_count, 3'd0);
        ack_dly = 0;
        run_acks(1, "late_refetch");
        chk("late_adr", adr_log[0], 20'hFFFF0);

        // randomized traffic
        do_reset();
        step();
        ack_dly = -1;
        fl_pm = 15;
        for (int blk = 0; blk < 6; blk++) begin
            rd_pct = 10 + $urandom_range(80);
            repeat (500) step();
        end
        fl_pm = 0;
        rd_pct = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
